mmio_periph: RTL and testbench

Memory-mapped peripheral responder on the data-memory side of the pipelined CPU. It decodes CPU load/store accesses in the 0x40000000–0x40000017 window and holds the peripheral register file: a reloadable 32-bit timer with interrupt flag, LED register, display-value register and a free-running SysTick counter. The CPU's data-memory stage drives it in parallel with data RAM and uses `Hit` to select its read data. It drives `led`, the display value and `irq`.

---
 rtl/mmio_periph.sv | 112 +++++++++++
 tb/tb_mmio_periph.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral block: reloadable timer with interrupt flag, LED and
// display registers, and a free-running SysTick counter, decoded at BASE..BASE+0x17.
module mmio_periph #(
  parameter logic [31:0] BASE   = 32'h40000000,
  parameter int          LED_W  = 16,
  parameter int          DISP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Hit,
  output logic [LED_W-1:0]  led,
  output logic [DISP_W-1:0] disp,
  output logic              irq
);

  logic [29:0] word_off;
  logic        in_win;
  logic        wr_en;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_disp, wr_systick;
  logic [31:0] th, tl, systick;
  logic [2:0]  tcon;
  logic        overflow;
  logic        ovf_set;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign unused_bits = &{1'b0, Address[1:0]};

  assign word_off = Address[31:2] - BASE[31:2];
  assign in_win   = word_off < 30'd6;
  assign Hit      = in_win;

  assign wr_en      = MemWrite & in_win;
  assign wr_th      = wr_en && (word_off == 30'd0);
  assign wr_tl      = wr_en && (word_off == 30'd1);
  assign wr_tcon    = wr_en && (word_off == 30'd2);
  assign wr_led     = wr_en && (word_off == 30'd3);
  assign wr_disp    = wr_en && (word_off == 30'd4);
  assign wr_systick = wr_en && (word_off == 30'd5);

  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign ovf_set  = overflow & tcon[1];

  always_comb begin
    rd_mux = '0;
    case (word_off)
      30'd0:   rd_mux = th;
      30'd1:   rd_mux = tl;
      30'd2:   rd_mux[2:0] = tcon;
      30'd3:   rd_mux[LED_W-1:0] = led;
      30'd4:   rd_mux[DISP_W-1:0] = disp;
      30'd5:   rd_mux = systick;
      default: rd_mux = '0;
    endcase
  end

  assign ReadData = (MemRead && in_win) ? rd_mux : '0;

  // A CPU write to TL beats both the increment and the reload; reload uses the old TH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
      tl <= '0;
    end else begin
      if (wr_th)
        th <= WriteData;
      if (wr_tl)
        tl <= WriteData;
      else if (overflow)
        tl <= th;
      else if (tcon[0])
        tl <= tl + 32'd1;
    end
  end

  // The overflow flag is OR-ed in so a same-cycle software clear never loses an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_tcon)
        tcon <= {WriteData[2] | ovf_set, WriteData[1:0]};
      else if (ovf_set)
        tcon[2] <= 1'b1;
      irq <= tcon[1] & tcon[2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led     <= '0;
      disp    <= '0;
      systick <= '0;
    end else begin
      if (wr_led)
        led <= WriteData[LED_W-1:0];
      if (wr_disp)
        disp <= WriteData[DISP_W-1:0];
      if (wr_systick)
        systick <= '0;
      else
        systick <= systick + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph: directed literal checks plus randomized
// traffic compared every cycle against a register-level behavioural model.
module tb_mmio_periph;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] A_TH = BASE + 32'h00;
  localparam logic [31:0] A_TL = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C;
  localparam logic [31:0] A_DISP = BASE + 32'h10;
  localparam logic [31:0] A_SYS = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [15:0] led;
  logic [15:0] disp;
  logic        irq;

  int errors = 0;
  int checks = 0;

  mmio_periph #(.BASE(BASE), .LED_W(16), .DISP_W(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Hit(Hit), .led(led), .disp(disp), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: the six registers as plain values, advanced once per edge.
  logic [31:0] m_regs [6];
  logic        m_irq;
  logic [31:0] n_regs [6];
  logic        n_irq;
  logic        m_ovf;
  int          m_idx;

  function automatic bit inWin(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd24);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a, input logic rd);
    if (!rd || !inWin(a)) return 32'h0;
    return m_regs[(a - BASE) >> 2];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) m_regs[i] = 32'h0;
      m_irq = 1'b0;
    end else begin
      n_regs = m_regs;
      m_ovf = m_regs[2][0] && (m_regs[1] == 32'hFFFF_FFFF);
      if (m_regs[2][0]) n_regs[1] = m_ovf ? m_regs[0] : m_regs[1] + 32'd1;
      if (m_ovf && m_regs[2][1]) n_regs[2][2] = 1'b1;
      n_regs[5] = m_regs[5] + 32'd1;
      n_irq = m_regs[2][1] & m_regs[2][2];
      if (MemWrite && inWin(Address)) begin
        m_idx = int'((Address - BASE) >> 2);
        case (m_idx)
          0: n_regs[0] = WriteData;
          1: n_regs[1] = WriteData;
          2: n_regs[2] = {29'h0, WriteData[2] | (m_ovf & m_regs[2][1]), WriteData[1:0]};
          3: n_regs[3] = {16'h0, WriteData[15:0]};
          4: n_regs[4] = {16'h0, WriteData[15:0]};
          default: n_regs[5] = 32'h0;
        endcase
      end
      m_regs = n_regs;
      m_irq = n_irq;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    checkOutput("hit", {31'h0, Hit}, {31'h0, inWin(Address)});
    checkOutput("readdata", ReadData, modelRead(Address, MemRead));
    checkOutput("led", {16'h0, led}, m_regs[3]);
    checkOutput("disp", {16'h0, disp}, m_regs[4]);
    checkOutput("irq", {31'h0, irq}, {31'h0, m_irq});
  end

  // Drive one cycle of bus activity starting just after a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd;
    MemWrite = wr;
    Address = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    MemRead = 1'b1;
    Address = a;
    #1;
    checkOutput(name, ReadData, exp);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    logic [31:0] d;

    @(negedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      readCheck("rst_read", BASE + 32'(i) * 32'd4, 32'h0);
      checkOutput("rst_hit", {31'h0, Hit}, 32'h1);
    end
    readCheck("rst_read_out", BASE + 32'd24, 32'h0);
    checkOutput("rst_hit_hi", {31'h0, Hit}, 32'h0);
    Address = 32'h3FFF_FFFC;
    #1;
    checkOutput("rst_hit_lo", {31'h0, Hit}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);

    @(negedge clk);
    #2 reset = 1'b1;
    MemRead = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    readCheck("systick_k", A_SYS, 32'd5);

    applyStimulus(1'b0, 1'b1, A_LED, 32'h1234_ABCD);
    applyStimulus(1'b0, 1'b1, A_DISP, 32'h0000_BEEF);
    checkOutput("led_lit", {16'h0, led}, 32'h0000_ABCD);
    checkOutput("disp_lit", {16'h0, disp}, 32'h0000_BEEF);
    readCheck("led_read", A_LED, 32'h0000_ABCD);

    applyStimulus(1'b0, 1'b1, A_TH, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, A_TL, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b1, A_TCON, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("ovf1_tl", A_TL, 32'hFFFF_FFFC);
    readCheck("ovf1_tcon", A_TCON, 32'h7);
    checkOutput("ovf1_irq_lag", {31'h0, irq}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ovf1_irq", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("pre_ovf2_tl", A_TL, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("ovf2_tl", A_TL, 32'hFFFF_FFFC);

    applyStimulus(1'b0, 1'b1, A_TCON, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("clr_irq", {31'h0, irq}, 32'h0);
    readCheck("clr_tcon", A_TCON, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("pre_ovf3_tl", A_TL, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, A_TCON, 32'h3);
    readCheck("ovf3_tcon_kept", A_TCON, 32'h7);
    readCheck("ovf3_tl", A_TL, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ovf3_irq", {31'h0, irq}, 32'h1);

    applyStimulus(1'b0, 1'b1, A_SYS, 32'hDEAD_BEEF);
    readCheck("sys_clr", A_SYS, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("sys_one", A_SYS, 32'h1);

    // Random traffic biased toward timer values near overflow.
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 6)
        a = BASE + 32'(sel) * 32'd4 + 32'($urandom_range(0, 3));
      else if (sel == 6)
        a = BASE + 32'd24 + 32'($urandom_range(0, 63));
      else
        a = $urandom;
      d = $urandom;
      if ((sel <= 1) && ($urandom_range(0, 3) != 0))
        d = 32'hFFFF_FFFF - 32'($urandom_range(0, 12));
      if ((sel == 2) && ($urandom_range(0, 4) != 0))
        d[0] = 1'b1;
      if ((sel == 5) && ($urandom_range(0, 3) != 0))
        a = A_LED;
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, a, d);
    end

    applyStimulus(1'b0, 1'b1, A_LED, 32'h0000_5A5A);
    applyStimulus(1'b0, 1'b1, A_TCON, 32'h0);
    applyStimulus(1'b0, 1'b1, A_TH, 32'hFFFF_FFF0);
    applyStimulus(1'b0, 1'b1, A_TL, 32'hFFFF_FFFD);
    applyStimulus(1'b0, 1'b1, A_TCON, 32'h3);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    readCheck("pre_rst_tl", A_TL, 32'hFFFF_FFF1);
    checkOutput("pre_rst_irq", {31'h0, irq}, 32'h1);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_irq", {31'h0, irq}, 32'h0);
    checkOutput("async_led", {16'h0, led}, 32'h0);
    checkOutput("async_read_tl", ReadData, 32'h0);
    for (int i = 0; i < 6; i++)
      readCheck("async_read", BASE + 32'(i) * 32'd4, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
